mem_arbiter: RTL and testbench

Two-port to one-port memory arbiter for the ButterFly core.
- Shares a single unified memory bus between the core's instruction-fetch port and its data port, for single-port SRAM / bus-bridge configurations.
- One outstanding transaction at a time.
- Data side has fixed priority; a starvation counter guarantees fetch progress.
- A watchdog terminates hung transactions with an error response.

---
 rtl/butterfly_pkg.sv | 25 ++
 rtl/mem_arbiter.sv | 175 +++++++++++++++++
 tb/tb_mem_arbiter.sv | 249 ++++++++++++++++++++++++
 3 files changed

// File: rtl/butterfly_pkg.sv
// butterfly_pkg: shared types and constants for the ButterFly memory arbiter.
//   arb_state_e        arbiter FSM states
//   GRANT_*            one-hot grant encodings (bit0 fetch, bit1 data)
//   tmo_width()        width of the watchdog counter for a given timeout
package butterfly_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GNT_I = 2'd1,
    GNT_D = 2'd2
  } arb_state_e;

  localparam logic [1:0] GRANT_NONE = 2'b00;
  localparam logic [1:0] GRANT_I    = 2'b01;
  localparam logic [1:0] GRANT_D    = 2'b10;

  localparam int TIMEOUT_CYCLES_DEFAULT = 255;

  // Width of the timeout counter, $clog2(TIMEOUT_CYCLES+1). A disabled
  // watchdog (0) still gets one bit so the counter stays a legal vector.
  function automatic int tmo_width(input int cycles);
    return (cycles == 0) ? 1 : $clog2(cycles + 1);
  endfunction

endpackage

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one memory bus between the instruction-fetch port and
// the data port. One transaction in flight; data has fixed priority, a
// starvation counter forces a fetch win after STARVE_MAX lost arbitrations,
// and a watchdog ends hung transactions with an error completion.
//
// Ports:
//   clk_i, rst_n_i                      clock, synchronous active-low reset
//   if_req_i, if_addr_i                 fetch request
//   if_rdata_o, if_ready_o, if_err_o    fetch completion
//   d_valid_i, d_we_i, d_addr_i,
//   d_wdata_i, d_wstrb_i                data request
//   d_rdata_o, d_ready_o, d_err_o       data completion
//   mem_valid_o, mem_we_o, mem_addr_o,
//   mem_wdata_o, mem_wstrb_o            downstream request
//   mem_rdata_i, mem_ready_i            downstream response
//   grant_o                             one-hot owner (00 when idle)
//
// State table:
//   IDLE  | no owner; arbitrate between fetch and data requests
//   GNT_I | fetch owns the bus, waiting for mem_ready_i or timeout
//   GNT_D | data owns the bus, waiting for mem_ready_i or timeout
module mem_arbiter
  import butterfly_pkg::*;
#(
  parameter int STARVE_MAX     = 4,
  parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEFAULT
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        if_req_i,
  input  logic [31:0] if_addr_i,
  output logic [31:0] if_rdata_o,
  output logic        if_ready_o,
  output logic        if_err_o,
  input  logic        d_valid_i,
  input  logic        d_we_i,
  input  logic [31:0] d_addr_i,
  input  logic [31:0] d_wdata_i,
  input  logic [3:0]  d_wstrb_i,
  output logic [31:0] d_rdata_o,
  output logic        d_ready_o,
  output logic        d_err_o,
  output logic        mem_valid_o,
  output logic        mem_we_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  output logic [3:0]  mem_wstrb_o,
  input  logic [31:0] mem_rdata_i,
  input  logic        mem_ready_i,
  output logic [1:0]  grant_o
);

  localparam int              TMO_W      = tmo_width(TIMEOUT_CYCLES);
  localparam logic [3:0]      STARVE_LIM = 4'(STARVE_MAX);
  localparam logic [TMO_W-1:0] TMO_LAST  =
    TMO_W'((TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1);
  localparam bit              TMO_EN     = (TIMEOUT_CYCLES != 0);

  arb_state_e        state_q, state_d;
  logic [3:0]        starve_q, starve_d;
  logic [TMO_W-1:0]  tmo_q, tmo_d;
  logic              we_q, we_d;
  logic [31:0]       addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [3:0]        wstrb_q, wstrb_d;

  logic              done;
  logic              timed_out;

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_q  <= IDLE;
      starve_q <= '0;
      tmo_q    <= '0;
      we_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      wstrb_q  <= '0;
    end else begin
      state_q  <= state_d;
      starve_q <= starve_d;
      tmo_q    <= tmo_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      wstrb_q  <= wstrb_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    starve_d    = starve_q;
    tmo_d       = tmo_q;
    we_d        = we_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    wstrb_d     = wstrb_q;
    done        = 1'b0;
    timed_out   = 1'b0;
    mem_valid_o = 1'b0;
    mem_we_o    = 1'b0;
    mem_addr_o  = '0;
    mem_wdata_o = '0;
    mem_wstrb_o = '0;
    grant_o     = GRANT_NONE;
    if_ready_o  = 1'b0;
    if_err_o    = 1'b0;
    if_rdata_o  = '0;
    d_ready_o   = 1'b0;
    d_err_o     = 1'b0;
    d_rdata_o   = '0;

    case (state_q)
      IDLE: begin
        tmo_d = '0;
        if (d_valid_i && !(if_req_i && starve_q == STARVE_LIM)) begin
          state_d = GNT_D;
          we_d    = d_we_i;
          addr_d  = d_addr_i;
          wdata_d = d_wdata_i;
          wstrb_d = d_wstrb_i;
          // Fetch only loses an arbitration when it was actually asking.
          if (if_req_i)
            starve_d = (starve_q == STARVE_LIM) ? STARVE_LIM : starve_q + 4'd1;
          else
            starve_d = '0;
        end else if (if_req_i) begin
          state_d  = GNT_I;
          we_d     = 1'b0;
          addr_d   = if_addr_i;
          wdata_d  = '0;
          wstrb_d  = '0;
          starve_d = '0;
        end else begin
          starve_d = '0;
        end
      end

      GNT_I, GNT_D: begin
        mem_valid_o = 1'b1;
        mem_we_o    = we_q;
        mem_addr_o  = addr_q;
        mem_wdata_o = wdata_q;
        mem_wstrb_o = wstrb_q;
        grant_o     = (state_q == GNT_I) ? GRANT_I : GRANT_D;
        tmo_d       = tmo_q + 1'b1;

        // A real response wins over the watchdog firing in the same cycle.
        if (mem_ready_i) begin
          done = 1'b1;
        end else if (TMO_EN && tmo_q == TMO_LAST) begin
          done      = 1'b1;
          timed_out = 1'b1;
        end

        if (done) begin
          state_d = IDLE;
          // A reset landing on the completion cycle abandons the transaction.
          if (state_q == GNT_I) begin
            if_ready_o = rst_n_i;
            if_err_o   = rst_n_i & timed_out;
            if_rdata_o = (rst_n_i && !timed_out) ? mem_rdata_i : '0;
          end else begin
            d_ready_o  = rst_n_i;
            d_err_o    = rst_n_i & timed_out;
            d_rdata_o  = (rst_n_i && !timed_out) ? mem_rdata_i : '0;
          end
        end
      end

      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;
  import butterfly_pkg::*;

  localparam int SM = 4;
  localparam int TO = 8;

  logic        clk_i = 1'b0;
  logic        rst_n_i;
  logic        if_req_i;
  logic [31:0] if_addr_i;
  logic [31:0] if_rdata_o;
  logic        if_ready_o, if_err_o;
  logic        d_valid_i, d_we_i;
  logic [31:0] d_addr_i, d_wdata_i;
  logic [3:0]  d_wstrb_i;
  logic [31:0] d_rdata_o;
  logic        d_ready_o, d_err_o;
  logic        mem_valid_o, mem_we_o;
  logic [31:0] mem_addr_o, mem_wdata_o;
  logic [3:0]  mem_wstrb_o;
  logic [31:0] mem_rdata_i;
  logic        mem_ready_i;
  logic [1:0]  grant_o;

  always #5 clk_i = ~clk_i;

  mem_arbiter #(.STARVE_MAX(SM), .TIMEOUT_CYCLES(TO)) dut (
    .clk_i(clk_i), .rst_n_i(rst_n_i),
    .if_req_i(if_req_i), .if_addr_i(if_addr_i), .if_rdata_o(if_rdata_o),
    .if_ready_o(if_ready_o), .if_err_o(if_err_o),
    .d_valid_i(d_valid_i), .d_we_i(d_we_i), .d_addr_i(d_addr_i),
    .d_wdata_i(d_wdata_i), .d_wstrb_i(d_wstrb_i), .d_rdata_o(d_rdata_o),
    .d_ready_o(d_ready_o), .d_err_o(d_err_o),
    .mem_valid_o(mem_valid_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
    .mem_wdata_o(mem_wdata_o), .mem_wstrb_o(mem_wstrb_o),
    .mem_rdata_i(mem_rdata_i), .mem_ready_i(mem_ready_i), .grant_o(grant_o)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Requester view of the world: what each port currently wants.
  bit          f_pend, d_pend, d_we;
  logic [31:0] f_addr, d_addr, d_wdata;
  logic [3:0]  d_wstrb;
  int          starve;

  task automatic step();
    @(posedge clk_i);
    @(negedge clk_i);
  endtask

  task automatic drive_reqs();
    if_req_i  = f_pend;
    if_addr_i = f_addr;
    d_valid_i = d_pend;
    d_we_i    = d_we;
    d_addr_i  = d_addr;
    d_wdata_i = d_wdata;
    d_wstrb_i = d_wstrb;
  endtask

  task automatic new_fetch(input logic [31:0] a);
    f_pend = 1; f_addr = a;
  endtask

  task automatic new_data(input bit we, input logic [31:0] a, input logic [31:0] wd, input logic [3:0] st);
    d_pend = 1; d_we = we; d_addr = a; d_wdata = wd; d_wstrb = st;
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, ".valid"}, 32'(mem_valid_o), 0);
    chk({tag, ".grant"}, 32'(grant_o), 0);
    chk({tag, ".addr"},  mem_addr_o, 0);
    chk({tag, ".we"},    32'(mem_we_o), 0);
    chk({tag, ".wdata"}, mem_wdata_o, 0);
    chk({tag, ".wstrb"}, 32'(mem_wstrb_o), 0);
    chk({tag, ".irdy"},  32'(if_ready_o), 0);
    chk({tag, ".drdy"},  32'(d_ready_o), 0);
    chk({tag, ".ierr"},  32'(if_err_o), 0);
    chk({tag, ".derr"},  32'(d_err_o), 0);
    chk({tag, ".irdata"}, if_rdata_o, 0);
    chk({tag, ".drdata"}, d_rdata_o, 0);
  endtask

  // One arbitration starting at an IDLE-cycle negedge. lat is the cycle
  // index (0 = first bus cycle) at which memory answers; lat >= TO means
  // the watchdog ends it. win reports who was granted (GRANT_NONE if idle).
  task automatic run_txn(input int lat, input bit allow_new,
                         input logic [31:0] rdata, output logic [1:0] win);
    logic [1:0]  exp_g;
    logic [31:0] e_addr, e_wdata;
    logic [3:0]  e_wstrb;
    bit          e_we, done, tmo;
    if (allow_new) begin
      if (!f_pend && $urandom_range(0, 1) == 1) new_fetch($urandom & 32'hFFFF_FFFC);
      if (!d_pend && $urandom_range(0, 1) == 1)
        new_data(1'($urandom), $urandom, $urandom, 4'($urandom));
    end
    drive_reqs();
    mem_ready_i = 1'($urandom);  // must be ignored while idle
    mem_rdata_i = $urandom;
    #1;
    chk("idle.valid", 32'(mem_valid_o), 0);
    chk("idle.grant", 32'(grant_o), 0);
    chk("idle.rdy", {30'd0, if_ready_o, d_ready_o}, 0);

    if (!f_pend && !d_pend) begin
      starve = 0;
      win = GRANT_NONE;
      step();
      return;
    end
    if (d_pend && !(f_pend && starve == SM)) exp_g = GRANT_D;
    else exp_g = GRANT_I;
    if (exp_g == GRANT_D && f_pend) starve = (starve < SM) ? starve + 1 : SM;
    else starve = 0;
    win = exp_g;

    if (exp_g == GRANT_D) begin
      e_we = d_we; e_addr = d_addr; e_wdata = d_wdata; e_wstrb = d_wstrb;
    end else begin
      e_we = 0; e_addr = f_addr; e_wdata = 0; e_wstrb = 0;
    end

    step();
    for (int k = 0; k < TO + 2; k++) begin
      mem_ready_i = (k == lat);
      mem_rdata_i = (k == lat) ? rdata : $urandom;
      #1;
      chk("bus.valid", 32'(mem_valid_o), 1);
      chk("bus.grant", 32'(grant_o), 32'(exp_g));
      chk("bus.addr",  mem_addr_o, e_addr);
      chk("bus.we",    32'(mem_we_o), 32'(e_we));
      chk("bus.wdata", mem_wdata_o, e_wdata);
      chk("bus.wstrb", 32'(mem_wstrb_o), 32'(e_wstrb));
      done = (k == lat) || (k == TO - 1);
      tmo  = done && (k != lat);
      if (exp_g == GRANT_I) begin
        chk("i.ready", 32'(if_ready_o), 32'(done));
        chk("i.err",   32'(if_err_o), 32'(tmo));
        chk("i.rdata", if_rdata_o, (done && !tmo) ? rdata : 32'h0);
        chk("d.idle",  {d_rdata_o[29:0], d_ready_o, d_err_o}, 0);
      end else begin
        chk("d.ready", 32'(d_ready_o), 32'(done));
        chk("d.err",   32'(d_err_o), 32'(tmo));
        chk("d.rdata", d_rdata_o, (done && !tmo) ? rdata : 32'h0);
        chk("i.idle",  {if_rdata_o[29:0], if_ready_o, if_err_o}, 0);
      end
      step();
      if (done) break;
    end
    mem_ready_i = 0;
    if (exp_g == GRANT_I) f_pend = 0; else d_pend = 0;
  endtask

  logic [1:0] w;
  int d_wins;

  initial begin
    f_pend = 0; d_pend = 0; starve = 0;
    f_addr = 0; d_addr = 0; d_wdata = 0; d_wstrb = 0; d_we = 0;
    rst_n_i = 0;
    mem_ready_i = 0; mem_rdata_i = 0;
    drive_reqs();
    @(negedge clk_i);
    repeat (3) begin
      step();
      chk_quiet("rst");
    end
    rst_n_i = 1;
    repeat (2) begin
      step();
      chk_quiet("post_rst");
    end

    // Single fetch, memory answers on the third bus cycle.
    new_fetch(32'h0000_0100);
    run_txn(2, 0, 32'h0000_0013, w);
    chk("fetch1.win", 32'(w), 32'(GRANT_I));

    // Simultaneous fetch and store: data first, then fetch.
    new_fetch(32'h0000_0104);
    new_data(1, 32'h0000_0200, 32'hDEAD_BEEF, 4'hF);
    run_txn(0, 0, 32'h1111_2222, w);
    chk("both.first", 32'(w), 32'(GRANT_D));
    run_txn(0, 0, 32'h3333_4444, w);
    chk("both.second", 32'(w), 32'(GRANT_I));

    // Starvation: data always requesting, fetch held.
    new_fetch(32'h0000_0500);
    d_wins = 0;
    for (int i = 0; i < 5; i++) begin
      if (!d_pend) new_data(0, 32'h0000_0600 + 32'(i * 4), 0, 0);
      run_txn(i % 2, 0, $urandom, w);
      if (w == GRANT_D) d_wins++;
    end
    chk("starve.dwins", 32'(d_wins), SM);
    chk("starve.fifth", 32'(w), 32'(GRANT_I));
    new_fetch(32'h0000_0504);
    run_txn(0, 0, $urandom, w);
    chk("starve.cleared", 32'(w), 32'(GRANT_D));
    run_txn(0, 0, $urandom, w);

    // Watchdog on a load that never gets an answer.
    new_data(0, 32'h0000_0300, 0, 0);
    run_txn(1000, 0, 32'hFFFF_FFFF, w);
    chk("tmo.win", 32'(w), 32'(GRANT_D));
    #1;
    chk("tmo.after_valid", 32'(mem_valid_o), 0);

    // Randomised mix.
    for (int i = 0; i < 300; i++)
      run_txn($urandom_range(0, TO + 1), 1, $urandom, w);
    while (f_pend || d_pend) run_txn($urandom_range(0, 3), 0, $urandom, w);

    // Reset in the second cycle of a data grant.
    new_data(0, 32'h0000_0700, 0, 0);
    drive_reqs();
    mem_ready_i = 0;
    step();
    chk("rmid.valid1", 32'(mem_valid_o), 1);
    chk("rmid.grant1", 32'(grant_o), 32'(GRANT_D));
    step();
    rst_n_i = 0;
    #1;
    chk("rmid.no_rdy", 32'(d_ready_o), 0);
    step();
    chk_quiet("rmid.after");
    rst_n_i = 1;
    d_pend = 0; starve = 0;
    drive_reqs();
    new_fetch(32'h0000_0800);
    run_txn(1, 0, 32'hCAFE_F00D, w);
    chk("rmid.fetch", 32'(w), 32'(GRANT_I));

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
